hazard_tracker: RTL and testbench



---
 rtl/hazard_tracker.sv | 181 ++++++++++++++++++
 tb/tb_hazard_tracker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// ============================================================================
//  Module      : hazard_tracker
//  Description : Pipeline register-use tracking and advance/stall/flush control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_tracker #(
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [4:0]      rs_id,
    input  logic [4:0]      rt_id,
    input  logic            uses_rt_id,
    input  logic [4:0]      wsel_id,
    input  logic            RegWrite_id,
    input  logic            MemRead_id,
    input  logic            dWEN_id,
    input  logic            halt_id,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            flush_ex,
    output logic [4:0]      rs_out_2,
    output logic [4:0]      rt_out_2,
    output logic [4:0]      wsel_out_2,
    output logic [4:0]      wsel_out_3,
    output logic [4:0]      wsel_out_4,
    output logic            RegWrite_out_3,
    output logic            RegWrite_out_4,
    output logic            dWEN_out_2,
    output logic            dREN_req,
    output logic            dWEN_req,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            pipe_en,
    output logic            halt,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [CNTW-1:0] C_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wsel;
        logic       reg_write;
        logic       mem_read;
        logic       dwen;
        logic       halt;
    } ex_stage_t;

    // Later stages keep only the fields this block consumes downstream;
    // source registers stop mattering once the instruction leaves EX.
    typedef struct packed {
        logic [4:0] wsel;
        logic       reg_write;
        logic       mem_read;
        logic       dwen;
        logic       halt;
    } mem_stage_t;

    typedef struct packed {
        logic [4:0] wsel;
        logic       reg_write;
        logic       halt;
    } wb_stage_t;

    ex_stage_t       l2_q, l2_d, id_fields;
    mem_stage_t      l3_q, l3_d;
    wb_stage_t       l4_q, l4_d;
    logic            dhit_seen_q, dhit_seen_d;
    logic            halt_q, halt_d;
    logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

    logic w_memop3;
    logic w_mem_busy;
    logic w_adv;
    logic w_load_use;
    logic w_bubble;
    logic w_count;

    always_comb begin
        id_fields.rs        = rs_id;
        id_fields.rt        = rt_id;
        id_fields.wsel      = wsel_id;
        id_fields.reg_write = RegWrite_id;
        id_fields.mem_read  = MemRead_id;
        id_fields.dwen      = dWEN_id;
        id_fields.halt      = halt_id;
    end

    assign w_memop3   = l3_q.mem_read | l3_q.dwen;
    assign w_mem_busy = w_memop3 & ~(dhit | dhit_seen_q);
    assign w_adv      = ihit & ~w_mem_busy & ~halt_q;

    assign w_load_use = l2_q.mem_read & l2_q.reg_write & (l2_q.wsel != 5'd0) &
                        ((l2_q.wsel == rs_id) | (uses_rt_id & (l2_q.wsel == rt_id)));

    // A taken branch squashes the ID instruction anyway, so it wins over the
    // interlock and fetch keeps moving toward the target.
    assign w_bubble = flush_ex | w_load_use;
    assign w_count  = ~halt_q & (~w_adv | (w_load_use & ~flush_ex));

    always_comb begin
        l2_d        = l2_q;
        l3_d        = l3_q;
        l4_d        = l4_q;
        dhit_seen_d = dhit_seen_q;
        halt_d      = halt_q | l4_q.halt;
        stall_cnt_d = stall_cnt_q;

        if (w_adv) begin
            l4_d.wsel      = l3_q.wsel;
            l4_d.reg_write = l3_q.reg_write;
            l4_d.halt      = l3_q.halt;

            l3_d.wsel      = l2_q.wsel;
            l3_d.reg_write = l2_q.reg_write;
            l3_d.mem_read  = l2_q.mem_read;
            l3_d.dwen      = l2_q.dwen;
            l3_d.halt      = l2_q.halt;

            l2_d = w_bubble ? '0 : id_fields;
        end

        // Remember a data completion that arrived while fetch held us, so the
        // access is neither re-requested nor waited on again.
        if (w_adv) begin
            dhit_seen_d = 1'b0;
        end else if (dhit) begin
            dhit_seen_d = 1'b1;
        end

        if (w_count) begin
            stall_cnt_d = stall_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            l2_q        <= '0;
            l3_q        <= '0;
            l4_q        <= '0;
            dhit_seen_q <= 1'b0;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            l2_q        <= l2_d;
            l3_q        <= l3_d;
            l4_q        <= l4_d;
            dhit_seen_q <= dhit_seen_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign rs_out_2       = l2_q.rs;
    assign rt_out_2       = l2_q.rt;
    assign wsel_out_2     = l2_q.wsel;
    assign dWEN_out_2     = l2_q.dwen;
    assign wsel_out_3     = l3_q.wsel;
    assign RegWrite_out_3 = l3_q.reg_write;
    assign wsel_out_4     = l4_q.wsel;
    assign RegWrite_out_4 = l4_q.reg_write;

    assign dREN_req   = l3_q.mem_read & ~dhit_seen_q;
    assign dWEN_req   = l3_q.dwen & ~dhit_seen_q;

    assign pipe_en    = w_adv;
    assign pc_en      = w_adv & ~(w_load_use & ~flush_ex);
    assign ifid_en    = pc_en;
    assign ifid_flush = w_adv & flush_ex;

    assign halt       = halt_q;
    assign stall_cnt  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_tracker.sv
// ============================================================================
//  Module      : tb_hazard_tracker
//  Description : Directed self-checking bench for hazard_tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_tracker;

    logic        CLK;
    logic        RST;
    logic [4:0]  rs_id, rt_id, wsel_id;
    logic        uses_rt_id, RegWrite_id, MemRead_id, dWEN_id, halt_id;
    logic        ihit, dhit, flush_ex;
    logic [4:0]  rs_out_2, rt_out_2, wsel_out_2, wsel_out_3, wsel_out_4;
    logic        RegWrite_out_3, RegWrite_out_4, dWEN_out_2;
    logic        dREN_req, dWEN_req, pc_en, ifid_en, ifid_flush, pipe_en, halt;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_tracker #(.CNTW(32)) dut (
        .CLK(CLK), .RST(RST),
        .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id), .wsel_id(wsel_id),
        .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id), .dWEN_id(dWEN_id),
        .halt_id(halt_id), .ihit(ihit), .dhit(dhit), .flush_ex(flush_ex),
        .rs_out_2(rs_out_2), .rt_out_2(rt_out_2), .wsel_out_2(wsel_out_2),
        .wsel_out_3(wsel_out_3), .wsel_out_4(wsel_out_4),
        .RegWrite_out_3(RegWrite_out_3), .RegWrite_out_4(RegWrite_out_4),
        .dWEN_out_2(dWEN_out_2), .dREN_req(dREN_req), .dWEN_req(dWEN_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .pipe_en(pipe_en), .halt(halt), .stall_cnt(stall_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                          input logic [4:0] ws, input logic rw, input logic mr,
                          input logic sw, input logic hl);
        rs_id = rs; rt_id = rt; uses_rt_id = urt; wsel_id = ws;
        RegWrite_id = rw; MemRead_id = mr; dWEN_id = sw; halt_id = hl;
    endtask

    task automatic apply_reset;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ihit = 0; dhit = 0; flush_ex = 0;
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset();
        #1;
        n_checks++; if ({rs_out_2, rt_out_2, wsel_out_2, wsel_out_3, wsel_out_4} !== 25'd0) begin n_fail++; $display("FAIL reset_regs: got %h expected 0", {rs_out_2, rt_out_2, wsel_out_2, wsel_out_3, wsel_out_4}); end
        n_checks++; if ({RegWrite_out_3, RegWrite_out_4, dWEN_out_2, dREN_req, dWEN_req, halt} !== 6'd0) begin n_fail++; $display("FAIL reset_flags: got %b expected 000000", {RegWrite_out_3, RegWrite_out_4, dWEN_out_2, dREN_req, dWEN_req, halt}); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_forward_pipeline;
        apply_reset();
        ihit = 1;
        set_id(5'd1, 5'd2, 1, 5'd3, 1, 0, 0, 0);
        #1;
        n_checks++; if ({pipe_en, pc_en, ifid_en, ifid_flush} !== 4'b1110) begin n_fail++; $display("FAIL fwd_ctrl: got %b expected 1110", {pipe_en, pc_en, ifid_en, ifid_flush}); end
        tick();
        n_checks++; if ({rs_out_2, rt_out_2, wsel_out_2} !== {5'd1, 5'd2, 5'd3}) begin n_fail++; $display("FAIL fwd_l2: got %0d/%0d/%0d expected 1/2/3", rs_out_2, rt_out_2, wsel_out_2); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        n_checks++; if ({wsel_out_3, RegWrite_out_3, wsel_out_2} !== {5'd3, 1'b1, 5'd0}) begin n_fail++; $display("FAIL fwd_l3: got ws3=%0d rw3=%b ws2=%0d expected 3/1/0", wsel_out_3, RegWrite_out_3, wsel_out_2); end
        tick();
        n_checks++; if ({wsel_out_4, RegWrite_out_4, wsel_out_3, RegWrite_out_3} !== {5'd3, 1'b1, 5'd0, 1'b0}) begin n_fail++; $display("FAIL fwd_l4: got ws4=%0d rw4=%b ws3=%0d rw3=%b expected 3/1/0/0", wsel_out_4, RegWrite_out_4, wsel_out_3, RegWrite_out_3); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL fwd_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_load_use;
        apply_reset();
        ihit = 1;
        set_id(5'd1, 5'd5, 0, 5'd5, 1, 1, 0, 0);      // lw $5
        tick();
        set_id(5'd5, 5'd1, 1, 5'd6, 1, 0, 0, 0);      // add $6,$5,$1
        #1;
        n_checks++; if ({pipe_en, pc_en, ifid_en, ifid_flush} !== 4'b1000) begin n_fail++; $display("FAIL lu_ctrl: got %b expected 1000", {pipe_en, pc_en, ifid_en, ifid_flush}); end
        tick();
        n_checks++; if ({wsel_out_2, wsel_out_3} !== {5'd0, 5'd5}) begin n_fail++; $display("FAIL lu_bubble: got ws2=%0d ws3=%0d expected 0/5", wsel_out_2, wsel_out_3); end
        n_checks++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt: got %0d expected 1", stall_cnt); end
        dhit = 1;
        #1;
        n_checks++; if ({dREN_req, pc_en, pipe_en} !== 3'b111) begin n_fail++; $display("FAIL lu_release: got %b expected 111", {dREN_req, pc_en, pipe_en}); end
        tick();
        dhit = 0;
        n_checks++; if ({rs_out_2, wsel_out_2, wsel_out_4} !== {5'd5, 5'd6, 5'd5}) begin n_fail++; $display("FAIL lu_add_l2: got rs2=%0d ws2=%0d ws4=%0d expected 5/6/5", rs_out_2, wsel_out_2, wsel_out_4); end
        n_checks++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL lu_cnt_after: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_flush_priority;
        apply_reset();
        ihit = 1;
        set_id(5'd1, 5'd5, 0, 5'd5, 1, 1, 0, 0);
        tick();
        set_id(5'd5, 5'd1, 1, 5'd6, 1, 0, 0, 0);
        flush_ex = 1;
        #1;
        n_checks++; if ({pipe_en, pc_en, ifid_en, ifid_flush} !== 4'b1111) begin n_fail++; $display("FAIL fl_ctrl: got %b expected 1111", {pipe_en, pc_en, ifid_en, ifid_flush}); end
        tick();
        flush_ex = 0;
        n_checks++; if ({wsel_out_2, rs_out_2, wsel_out_3} !== {5'd0, 5'd0, 5'd5}) begin n_fail++; $display("FAIL fl_bubble: got ws2=%0d rs2=%0d ws3=%0d expected 0/0/5", wsel_out_2, rs_out_2, wsel_out_3); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL fl_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_store_wait;
        apply_reset();
        ihit = 1;
        set_id(5'd1, 5'd2, 1, 5'd0, 0, 0, 1, 0);      // sw
        tick();
        n_checks++; if (dWEN_out_2 !== 1'b1) begin n_fail++; $display("FAIL sw_l2: got %b expected 1", dWEN_out_2); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        ihit = 0; dhit = 1;                           // wait cycle 1
        #1;
        n_checks++; if ({dWEN_req, pipe_en, pc_en} !== 3'b100) begin n_fail++; $display("FAIL sw_c1: got %b expected 100", {dWEN_req, pipe_en, pc_en}); end
        tick();
        dhit = 0;                                     // wait cycle 2
        #1;
        n_checks++; if ({dWEN_req, pipe_en} !== 2'b00) begin n_fail++; $display("FAIL sw_c2: got %b expected 00", {dWEN_req, pipe_en}); end
        tick();                                       // wait cycle 3
        tick();
        ihit = 1;
        #1;
        n_checks++; if ({pipe_en, pc_en, dWEN_req} !== 3'b110) begin n_fail++; $display("FAIL sw_resume: got %b expected 110", {pipe_en, pc_en, dWEN_req}); end
        tick();
        n_checks++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL sw_cnt: got %0d expected 3", stall_cnt); end
    endtask

    task automatic test_load_wait;
        apply_reset();
        ihit = 1;
        set_id(5'd1, 5'd0, 0, 5'd7, 1, 1, 0, 0);      // lw $7
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_id(5'd2, 5'd3, 1, 5'd9, 1, 0, 0, 0);      // add $9 waiting in ID
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if ({pipe_en, dREN_req} !== 2'b01) begin n_fail++; $display("FAIL lw_wait%0d: got pe/dren=%b expected 01", i, {pipe_en, dREN_req}); end
            tick();
            n_checks++; if ({wsel_out_2, wsel_out_3, wsel_out_4} !== {5'd0, 5'd7, 5'd0}) begin n_fail++; $display("FAIL lw_hold%0d: got %0d/%0d/%0d expected 0/7/0", i, wsel_out_2, wsel_out_3, wsel_out_4); end
        end
        dhit = 1;
        #1;
        n_checks++; if (pipe_en !== 1'b1) begin n_fail++; $display("FAIL lw_dhit_adv: got %b expected 1", pipe_en); end
        tick();
        dhit = 0;
        n_checks++; if ({wsel_out_2, wsel_out_3, wsel_out_4} !== {5'd9, 5'd0, 5'd7}) begin n_fail++; $display("FAIL lw_after: got %0d/%0d/%0d expected 9/0/7", wsel_out_2, wsel_out_3, wsel_out_4); end
        n_checks++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL lw_cnt: got %0d expected 4", stall_cnt); end
    endtask

    task automatic test_halt;
        apply_reset();
        ihit = 1;
        set_id(0, 0, 0, 0, 0, 0, 0, 1);               // halt
        tick();
        set_id(5'd1, 5'd1, 1, 5'd4, 1, 0, 0, 0);
        tick();
        set_id(5'd1, 5'd1, 1, 5'd8, 1, 0, 0, 0);
        tick();
        n_checks++; if (halt !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b expected 0", halt); end
        set_id(5'd1, 5'd1, 1, 5'd10, 1, 0, 0, 0);
        tick();
        n_checks++; if ({halt, pipe_en, pc_en} !== 3'b100) begin n_fail++; $display("FAIL halt_set: got %b expected 100", {halt, pipe_en, pc_en}); end
        n_checks++; if ({wsel_out_2, wsel_out_3, wsel_out_4} !== {5'd10, 5'd8, 5'd4}) begin n_fail++; $display("FAIL halt_latch: got %0d/%0d/%0d expected 10/8/4", wsel_out_2, wsel_out_3, wsel_out_4); end
        set_id(5'd3, 5'd3, 1, 5'd12, 1, 0, 0, 0);
        tick(); tick(); tick();
        n_checks++; if ({wsel_out_2, wsel_out_3, wsel_out_4, halt} !== {5'd10, 5'd8, 5'd4, 1'b1}) begin n_fail++; $display("FAIL halt_frozen: got %0d/%0d/%0d h=%b expected 10/8/4/1", wsel_out_2, wsel_out_3, wsel_out_4, halt); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL halt_cnt: got %0d expected 0", stall_cnt); end
        #2;
        RST = 1'b1;                                   // asserted between edges
        #1;
        n_checks++; if ({halt, wsel_out_2, wsel_out_3, wsel_out_4, RegWrite_out_4} !== 17'd0) begin n_fail++; $display("FAIL halt_async_rst: got %h expected 0", {halt, wsel_out_2, wsel_out_3, wsel_out_4, RegWrite_out_4}); end
        tick();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ihit = 0; dhit = 0; flush_ex = 0;
        test_reset();
        test_forward_pipeline();
        test_load_use();
        test_flush_priority();
        test_store_wait();
        test_load_wait();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
